// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 codes, FSM states
// and the byte-enable helper used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MREQ   = 3'd1,
    S_MWAIT  = 3'd2,
    S_MREQ2  = 3'd3,
    S_MWAIT2 = 3'd4,
    S_RESP   = 3'd5
  } lsu_state_e;

  // Access size in bytes encoded by funct3[1:0] (1/2/4/8).
  function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  // Byte mask over a two-word window; wide enough for 64-bit data (16 lanes).
  function automatic logic [15:0] byte_mask(input logic [3:0] size, input logic [2:0] off);
    logic [15:0] m;
    m = (16'd1 << size) - 16'd1;
    return m << off;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Load data extraction: shifts the two-word merged read data down by the byte
// offset, keeps the access size and sign- or zero-extends per funct3[2].
module lsu_load_extract
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0]          merged,
  input  logic [$clog2(DATA_W/8)-1:0]  off,
  input  logic [2:0]                   funct3,
  output logic [DATA_W-1:0]            result
);

  localparam int IDXW = $clog2(DATA_W);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic [6:0]        nbits;
  logic [IDXW-1:0]   sign_idx;
  logic              sign_bit;

  always_comb begin
    shifted  = DATA_W'(merged >> {off, 3'b000});
    nbits    = {access_bytes(funct3), 3'b000};
    // A full-width access shifts the 1 out entirely, leaving keep all ones.
    keep     = (DATA_W'(1) << nbits) - DATA_W'(1);
    sign_idx = IDXW'(nbits - 7'd1);
    sign_bit = shifted[sign_idx] & ~funct3[2];
    result   = shifted & keep;
    if (sign_bit) begin
      result = result | ~keep;
    end
  end

endmodule

// File: rtl/lsu_mem_align.sv
// Load/store alignment unit with one access outstanding. Defining LSU_MISALIGN_EN
// splits misaligned accesses into two memory beats instead of faulting them.
module lsu_mem_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_err,
  output logic [2:0]          dbg_state
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
`ifdef LSU_MISALIGN_EN
  localparam int BEATS = 2;
`else
  localparam int BEATS = 1;
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload stay stable until that edge.

  lsu_state_e        state;
  logic              store_r;
  logic [2:0]        f3_r;
  logic [OFFW-1:0]   off_r;
`ifdef LSU_MISALIGN_EN
  logic              split_r;
  logic [DATA_W-1:0] wdata_hi_r;
  logic [NB-1:0]     mask_hi_r;
  logic [DATA_W-1:0] rdata1_r;
`endif

  logic [OFFW-1:0]         req_off;
  logic [3:0]              req_size;
  logic [ADDR_W-1:0]       req_word;
  logic [BEATS*DATA_W-1:0] req_wsh;
  logic [BEATS*NB-1:0]     req_mask;
  logic                    req_illegal;
  logic                    req_misal;
  logic                    req_fault;
  logic [2*DATA_W-1:0]     ext_in;
  logic [DATA_W-1:0]       ext_out;

  assign req_off   = req_addr[OFFW-1:0];
  assign req_size  = access_bytes(req_funct3);
  assign req_word  = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign req_wsh   = (BEATS*DATA_W)'(req_wdata) << {req_off, 3'b000};
  assign req_mask  = (BEATS*NB)'(byte_mask(req_size, 3'(req_off)));
  assign req_illegal = (req_funct3 == 3'b111) || (req_store && req_funct3[2]) ||
                       ((DATA_W == 32) && ((req_funct3 == F3_D) || (req_funct3 == F3_WU)));
  assign req_misal = ((4'(req_off) & (req_size - 4'd1)) != 4'd0) ||
                     ((5'(req_off) + 5'(req_size)) > 5'(NB));
`ifdef LSU_MISALIGN_EN
  assign req_fault = req_illegal;
  assign ext_in    = (state == S_MWAIT2) ? {mem_rdata, rdata1_r} : {{DATA_W{1'b0}}, mem_rdata};
`else
  assign req_fault = req_illegal || req_misal;
  assign ext_in    = {{DATA_W{1'b0}}, mem_rdata};
`endif

  assign dbg_state = state;

  lsu_load_extract #(.DATA_W(DATA_W)) u_extract (
    .merged (ext_in),
    .off    (off_r),
    .funct3 (f3_r),
    .result (ext_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= '0;
      mem_wdata     <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
      store_r       <= 1'b0;
      f3_r          <= '0;
      off_r         <= '0;
`ifdef LSU_MISALIGN_EN
      split_r       <= 1'b0;
      wdata_hi_r    <= '0;
      mask_hi_r     <= '0;
      rdata1_r      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            store_r   <= req_store;
            f3_r      <= req_funct3;
            off_r     <= req_off;
`ifdef LSU_MISALIGN_EN
            split_r    <= req_misal;
            wdata_hi_r <= req_wsh[2*DATA_W-1:DATA_W];
            mask_hi_r  <= req_store ? req_mask[2*NB-1:NB] : '0;
`endif
            if (req_fault) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
              state      <= S_RESP;
            end else begin
              mem_req_valid <= 1'b1;
              mem_addr      <= req_word;
              mem_we        <= req_store ? req_mask[NB-1:0] : '0;
              mem_wdata     <= req_wsh[DATA_W-1:0];
              state         <= S_MREQ;
            end
          end
        end
        S_MREQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_we        <= '0;
            if (!store_r) begin
              state <= S_MWAIT;
`ifdef LSU_MISALIGN_EN
            end else if (split_r) begin
              mem_req_valid <= 1'b1;
              mem_addr      <= mem_addr + ADDR_W'(NB);
              mem_we        <= mask_hi_r;
              mem_wdata     <= wdata_hi_r;
              state         <= S_MREQ2;
`endif
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_data  <= '0;
              state      <= S_RESP;
            end
          end
        end
        S_MWAIT: begin
          if (mem_rvalid) begin
`ifdef LSU_MISALIGN_EN
            if (split_r) begin
              rdata1_r      <= mem_rdata;
              mem_req_valid <= 1'b1;
              mem_addr      <= mem_addr + ADDR_W'(NB);
              mem_we        <= '0;
              state         <= S_MREQ2;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_data  <= ext_out;
              state      <= S_RESP;
            end
`else
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= ext_out;
            state      <= S_RESP;
`endif
          end
        end
`ifdef LSU_MISALIGN_EN
        S_MREQ2: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_we        <= '0;
            if (store_r) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_data  <= '0;
              state      <= S_RESP;
            end else begin
              state <= S_MWAIT2;
            end
          end
        end
        S_MWAIT2: begin
          if (mem_rvalid) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= ext_out;
            state      <= S_RESP;
          end
        end
`endif
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
